// File: rtl/mem_subword_adapter.sv
// Byte/half/word load-store adapter in front of a 32-bit word-only memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module mem_subword_adapter #(
   parameter int ADDR_WIDTH  = 32,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_exception,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic [31:0]           mem_read_data,
   input  logic                  mem_read_exception,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [31:0]           mem_write_data,
   input  logic                  mem_write_exception
);

   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

   state_t                  state, state_next;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             merged_q;
   logic [31:0]             rdata_q;
   logic                    exc_q;
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [ADDR_WIDTH-1:0]   aligned;
   logic                    misaligned;
   logic                    bad_req;

   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      if (size == 2'd1) begin
         if (lane[1]) r[31:16] = wd;
         else         r[15:0]  = wd;
      end else begin
         case (lane)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end
      return r;
   endfunction

   // Without alignment checking, the request address is forced to natural alignment.
   always_comb begin
      acc_addr = req_addr;
      if (!CHECK_ALIGN) begin
         if (req_size == 2'd1)      acc_addr[0]   = 1'b0;
         else if (req_size == 2'd2) acc_addr[1:0] = 2'b00;
      end
   end

   assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   assign bad_req    = (req_size == 2'd3) || (CHECK_ALIGN && misaligned);

   assign aligned           = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_read_address  = aligned;
   assign mem_write_address = aligned;
   assign mem_write_data    = merged_q;
   assign resp_rdata        = rdata_q;
   assign resp_exception    = exc_q;

   always_comb begin
      state_next       = state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      mem_write_enable = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (bad_req)               state_next = RESP;
               else if (!req_write)       state_next = LOAD;
               else if (req_size == 2'd2) state_next = WRITE;
               else                       state_next = MERGE;
            end
         end
         LOAD:  state_next = RESP;
         MERGE: state_next = mem_read_exception ? RESP : WRITE;
         WRITE: begin
            mem_write_enable = 1'b1;
            state_next       = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_next;
   end

   // merged_q doubles as the latched store data until the read half of a merge completes.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         size_q   <= 2'd0;
         uns_q    <= 1'b0;
         addr_q   <= '0;
         merged_q <= 32'd0;
         rdata_q  <= 32'd0;
         exc_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_q   <= req_size;
                  uns_q    <= req_unsigned;
                  addr_q   <= acc_addr;
                  merged_q <= req_wdata;
                  rdata_q  <= 32'd0;
                  exc_q    <= bad_req;
               end
            end
            LOAD: begin
               rdata_q <= mem_read_exception ? 32'd0
                          : extract_lane(mem_read_data, size_q, addr_q[1:0], uns_q);
               exc_q   <= mem_read_exception;
            end
            MERGE: begin
               if (!mem_read_exception)
                  merged_q <= merge_lane(mem_read_data, merged_q[15:0], size_q, addr_q[1:0]);
               exc_q <= mem_read_exception;
            end
            WRITE: exc_q <= mem_write_exception;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_subword_adapter.sv
// Scoreboard bench for mem_subword_adapter with a small word-addressed memory model.
module tb_mem_subword_adapter;

   logic        CLK   = 1'b0;
   logic        RESET = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        req_ready, resp_valid, resp_exception, mem_write_enable;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata, mem_read_address, mem_read_data, mem_write_address, mem_write_data;
   logic        rd_exc = 1'b0, wr_exc = 1'b0;

   logic        na_req_valid = 1'b0, na_resp_ready = 1'b1, na_zero = 1'b0;
   logic [31:0] na_req_addr = 32'd0;
   logic        na_req_ready, na_resp_valid, na_resp_exception, na_mem_write_enable;
   logic [31:0] na_resp_rdata, na_mem_read_address, na_mem_read_data;
   logic [31:0] na_mem_write_address, na_mem_write_data;

   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = 8'd0;
   logic [31:0] pl_val = 32'd0;
   int          wr_count = 0;
   logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;

   int nvec = 0;
   int nbad = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        exc;
      int          lat;
   } exp_t;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   mem_subword_adapter #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) u_dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_exception(resp_exception),
      .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
      .mem_read_exception(rd_exc), .mem_write_enable(mem_write_enable),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
      .mem_write_exception(wr_exc)
   );

   mem_subword_adapter #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b0)) u_dut_na (
      .CLK(CLK), .RESET(RESET),
      .req_valid(na_req_valid), .req_ready(na_req_ready), .req_write(na_zero),
      .req_size(2'd2), .req_unsigned(na_zero), .req_addr(na_req_addr),
      .req_wdata(32'd0), .resp_valid(na_resp_valid), .resp_ready(na_resp_ready),
      .resp_rdata(na_resp_rdata), .resp_exception(na_resp_exception),
      .mem_read_address(na_mem_read_address), .mem_read_data(na_mem_read_data),
      .mem_read_exception(na_zero), .mem_write_enable(na_mem_write_enable),
      .mem_write_address(na_mem_write_address), .mem_write_data(na_mem_write_data),
      .mem_write_exception(na_zero)
   );

   assign mem_read_data    = mem[mem_read_address[9:2]];
   assign na_mem_read_data = mem[na_mem_read_address[9:2]];

   always @(posedge CLK) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (RESET && mem_write_enable) begin
         wr_count <= wr_count + 1;
         wr_addr  <= mem_write_address;
         wr_data  <= mem_write_data;
         if (!wr_exc) mem[mem_write_address[9:2]] <= mem_write_data;
      end
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      @(negedge CLK);
      pl_idx = idx; pl_val = val; pl_en = 1'b1;
      @(negedge CLK);
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      while (!req_ready && n < 20) begin @(negedge CLK); n++; end
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge CLK);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      do begin @(negedge CLK); lat++; end while (!resp_valid && lat < 20);
   endtask

   task automatic test_reset();
      logic [31:0] obs [8];
      logic [31:0] req [8];
      string       nm [8];
      #2 RESET = 1'b0;
      #1;
      obs = '{{31'd0, req_ready}, {31'd0, resp_valid}, resp_rdata, {31'd0, resp_exception},
              {31'd0, mem_write_enable}, mem_read_address, mem_write_address, mem_write_data};
      req = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      nm  = '{"rst_req_ready", "rst_resp_valid", "rst_resp_rdata", "rst_resp_exc",
              "rst_wen", "rst_raddr", "rst_waddr", "rst_wdata"};
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (obs[i] !== req[i]) begin
            nbad++; $display("FAIL %s: got %h expected %h", nm[i], obs[i], req[i]);
         end
      end
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_byte_store();
      int lat, n0;
      exp_t e;
      preload(8'h40, 32'hAABBCCDD);
      n0 = wr_count;
      issue(1'b1, 2'd0, 1'b0, 32'h102, 32'hDEADBE11);
      exp_q.push_back('{32'h0, 1'b0, 3});
      wait_resp(lat);
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL bst_lat: got %0d expected %0d", lat, e.lat); end
      nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL bst_exc: got %b expected %b", resp_exception, e.exc); end
      nvec++; if (resp_rdata !== e.rdata) begin nbad++; $display("FAIL bst_rdata: got %h expected %h", resp_rdata, e.rdata); end
      nvec++; if (wr_count !== n0 + 1) begin nbad++; $display("FAIL bst_wcount: got %0d expected %0d", wr_count, n0 + 1); end
      nvec++; if (wr_addr !== 32'h100) begin nbad++; $display("FAIL bst_waddr: got %h expected 00000100", wr_addr); end
      nvec++; if (wr_data !== 32'hAA11CCDD) begin nbad++; $display("FAIL bst_wdata: got %h expected aa11ccdd", wr_data); end
      nvec++; if (mem[8'h40] !== 32'hAA11CCDD) begin nbad++; $display("FAIL bst_mem: got %h expected aa11ccdd", mem[8'h40]); end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
      logic        u  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] a  [5] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
      logic [31:0] r  [5] = '{32'hFFFFFFAA, 32'h0000AABB, 32'hFFFFCCDD, 32'h000000CC, 32'hAABBCCDD};
      int lat;
      exp_t e;
      preload(8'h40, 32'hAABBCCDD);
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, sz[i], u[i], a[i], 32'hFFFFFFFF);
         exp_q.push_back('{r[i], 1'b0, 2});
         wait_resp(lat);
         e = exp_q.pop_front();
         nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL ld%0d_lat: got %0d expected %0d", i, lat, e.lat); end
         nvec++; if (resp_rdata !== e.rdata) begin nbad++; $display("FAIL ld%0d_rdata: got %h expected %h", i, resp_rdata, e.rdata); end
         nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL ld%0d_exc: got %b expected %b", i, resp_exception, e.exc); end
      end
   endtask

   task automatic test_misalign();
      logic        w  [3] = '{1'b0, 1'b0, 1'b1};
      logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
      logic [31:0] a  [3] = '{32'h101, 32'h100, 32'h103};
      int lat, n0;
      exp_t e;
      preload(8'h40, 32'hAABBCCDD);
      for (int i = 0; i < 3; i++) begin
         n0 = wr_count;
         issue(w[i], sz[i], 1'b0, a[i], 32'h5A5A5A5A);
         exp_q.push_back('{32'h0, 1'b1, 1});
         wait_resp(lat);
         e = exp_q.pop_front();
         nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL mis%0d_lat: got %0d expected %0d", i, lat, e.lat); end
         nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL mis%0d_exc: got %b expected %b", i, resp_exception, e.exc); end
         nvec++; if (resp_rdata !== e.rdata) begin nbad++; $display("FAIL mis%0d_rdata: got %h expected %h", i, resp_rdata, e.rdata); end
         nvec++; if (wr_count !== n0) begin nbad++; $display("FAIL mis%0d_nowrite: got %0d expected %0d", i, wr_count, n0); end
      end
      @(negedge CLK);
      na_req_valid = 1'b1; na_req_addr = 32'h101;
      @(posedge CLK);
      #1 na_req_valid = 1'b0;
      exp_q.push_back('{32'hAABBCCDD, 1'b0, 2});
      lat = 0;
      do begin @(negedge CLK); lat++; end while (!na_resp_valid && lat < 20);
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL na_lat: got %0d expected %0d", lat, e.lat); end
      nvec++; if (na_resp_rdata !== e.rdata) begin nbad++; $display("FAIL na_rdata: got %h expected %h", na_resp_rdata, e.rdata); end
      nvec++; if (na_resp_exception !== e.exc) begin nbad++; $display("FAIL na_exc: got %b expected %b", na_resp_exception, e.exc); end
      nvec++; if (na_mem_read_address !== 32'h100) begin nbad++; $display("FAIL na_raddr: got %h expected 00000100", na_mem_read_address); end
      nvec++;
      if ({na_mem_write_enable, na_mem_write_address, na_mem_write_data} !== {1'b0, 32'h100, 32'h0}) begin
         nbad++; $display("FAIL na_wport: got %b/%h/%h expected 0/00000100/00000000",
                          na_mem_write_enable, na_mem_write_address, na_mem_write_data);
      end
      @(negedge CLK);
   endtask

   task automatic test_mem_faults();
      int lat, n0;
      exp_t e;
      preload(8'h41, 32'h01020304);
      n0 = wr_count;
      rd_exc = 1'b1;
      issue(1'b1, 2'd1, 1'b0, 32'h104, 32'h0000BEEF);
      exp_q.push_back('{32'h0, 1'b1, 2});
      wait_resp(lat);
      rd_exc = 1'b0;
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL rdf_lat: got %0d expected %0d", lat, e.lat); end
      nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL rdf_exc: got %b expected %b", resp_exception, e.exc); end
      nvec++; if (wr_count !== n0) begin nbad++; $display("FAIL rdf_nowrite: got %0d expected %0d", wr_count, n0); end
      nvec++; if (mem[8'h41] !== 32'h01020304) begin nbad++; $display("FAIL rdf_mem: got %h expected 01020304", mem[8'h41]); end
      wr_exc = 1'b1;
      issue(1'b1, 2'd2, 1'b0, 32'h10C, 32'hCAFEF00D);
      exp_q.push_back('{32'h0, 1'b1, 2});
      wait_resp(lat);
      wr_exc = 1'b0;
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL wrf_lat: got %0d expected %0d", lat, e.lat); end
      nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL wrf_exc: got %b expected %b", resp_exception, e.exc); end
      nvec++; if (resp_rdata !== e.rdata) begin nbad++; $display("FAIL wrf_rdata: got %h expected %h", resp_rdata, e.rdata); end
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_t e;
      preload(8'h40, 32'hAABBCCDD);
      resp_ready = 1'b0;
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      exp_q.push_back('{32'hAABBCCDD, 1'b0, 2});
      wait_resp(lat);
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL hold_lat: got %0d expected %0d", lat, e.lat); end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         nvec++; if (resp_valid !== 1'b1) begin nbad++; $display("FAIL hold%0d_valid: got %b expected 1", i, resp_valid); end
         nvec++; if (resp_rdata !== e.rdata) begin nbad++; $display("FAIL hold%0d_rdata: got %h expected %h", i, resp_rdata, e.rdata); end
         nvec++; if (req_ready !== 1'b0) begin nbad++; $display("FAIL hold%0d_req_ready: got %b expected 0", i, req_ready); end
      end
      resp_ready = 1'b1;
      @(negedge CLK);
      nvec++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL rel_req_ready: got %b expected 1", req_ready); end
      nvec++; if (resp_valid !== 1'b0) begin nbad++; $display("FAIL rel_resp_valid: got %b expected 0", resp_valid); end
      exp_q.push_back('{32'hFFFFFFAA, 1'b0, 2});
      exp_q.push_back('{32'h0000CCDD, 1'b0, 2});
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
      wait_resp(lat);
      e = exp_q.pop_front();
      nvec++; if (resp_rdata !== e.rdata || lat !== e.lat) begin nbad++; $display("FAIL b2b0: got %h/%0d expected %h/%0d", resp_rdata, lat, e.rdata, e.lat); end
      issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
      wait_resp(lat);
      e = exp_q.pop_front();
      nvec++; if (resp_rdata !== e.rdata || lat !== e.lat) begin nbad++; $display("FAIL b2b1: got %h/%0d expected %h/%0d", resp_rdata, lat, e.rdata, e.lat); end
   endtask

   task automatic test_reset_midwrite();
      int   lat, n0;
      logic seen;
      exp_t e;
      preload(8'h40, 32'hAABBCCDD);
      n0 = wr_count;
      issue(1'b1, 2'd0, 1'b0, 32'h100, 32'h00000055);
      @(negedge CLK);
      @(negedge CLK);
      nvec++; if (mem_write_enable !== 1'b1) begin nbad++; $display("FAIL mrst_wen_pre: got %b expected 1", mem_write_enable); end
      RESET = 1'b0;
      #1;
      nvec++; if (mem_write_enable !== 1'b0) begin nbad++; $display("FAIL mrst_wen_drop: got %b expected 0", mem_write_enable); end
      nvec++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL mrst_req_ready: got %b expected 1", req_ready); end
      @(negedge CLK);
      @(negedge CLK);
      nvec++; if (mem[8'h40] !== 32'hAABBCCDD) begin nbad++; $display("FAIL mrst_mem: got %h expected aabbccdd", mem[8'h40]); end
      nvec++; if (wr_count !== n0) begin nbad++; $display("FAIL mrst_nowrite: got %0d expected %0d", wr_count, n0); end
      RESET = 1'b1;
      seen = 1'b0;
      repeat (4) begin @(negedge CLK); if (resp_valid) seen = 1'b1; end
      nvec++; if (seen !== 1'b0) begin nbad++; $display("FAIL mrst_noresp: got %b expected 0", seen); end
      n0 = wr_count;
      issue(1'b1, 2'd2, 1'b0, 32'h108, 32'h12345678);
      exp_q.push_back('{32'h0, 1'b0, 2});
      wait_resp(lat);
      e = exp_q.pop_front();
      nvec++; if (lat !== e.lat) begin nbad++; $display("FAIL post_lat: got %0d expected %0d", lat, e.lat); end
      nvec++; if (resp_exception !== e.exc) begin nbad++; $display("FAIL post_exc: got %b expected %b", resp_exception, e.exc); end
      nvec++; if (wr_count !== n0 + 1) begin nbad++; $display("FAIL post_wcount: got %0d expected %0d", wr_count, n0 + 1); end
      nvec++; if (mem[8'h42] !== 32'h12345678) begin nbad++; $display("FAIL post_mem: got %h expected 12345678", mem[8'h42]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_store();
      test_loads();
      test_misalign();
      test_mem_faults();
      test_back_to_back();
      test_reset_midwrite();
      @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/mem_subword_adapter.md
Name: mem_subword_adapter

Overview:
- Sits directly upstream of the 32-bit memory model, between the core's load/store unit and the memory's read and write ports.
- Converts byte, halfword and word load/store requests into aligned full-word memory accesses.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- Loads have their lane extracted and zero- or sign-extended. The adapter flags misaligned accesses and memory exceptions back to the core over a valid/ready request and response handshake.

Parameters:
- ADDR_WIDTH, 32: width of request and memory addresses.
- CHECK_ALIGN, 1: 1 = misaligned half/word access returns an exception. 0 = address low bits are cleared to the natural alignment of the access size, with no exception.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  adapter can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_exception  out  1  misaligned, illegal size, or memory exception.
- mem_read_address  out  ADDR_WIDTH  word-aligned read address to memory.
- mem_read_data  in  32  combinational read data from memory.
- mem_read_exception  in  1  memory read fault.
- mem_write_enable  out  1  one-cycle word write strobe.
- mem_write_address  out  ADDR_WIDTH  word-aligned write address.
- mem_write_data  out  32  merged full word.
- mem_write_exception  in  1  memory write fault.

Behaviour:
- Reset (RESET low, asynchronous):
  - state = IDLE; all latched request registers = 0.
  - req_ready = 1; resp_valid = 0, resp_rdata = 0, resp_exception = 0.
  - mem_write_enable = 0; mem_* address/data = 0.
  - A reset mid-operation drops the request: no write is issued and no response is produced.
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, size, unsigned, addr and wdata. Acceptance is the posedge with req_valid && req_ready.
  - Next state:
    - misaligned (half with addr[0]=1; word with addr[1:0]!=0; CHECK_ALIGN=1) or size=3 -> RESP with exception=1.
    - load -> LOAD.
    - word store -> WRITE, with merged = wdata.
    - byte/half store -> MERGE.
- LOAD:
  - mem_read_address = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Capture lane: byte = data[8*a+7:8*a] with a = addr[1:0]; half = data[16*h+15:16*h] with h = addr[1]; word = all 32 bits.
  - Extend per req_unsigned; store into resp_rdata.
  - If mem_read_exception: resp_rdata = 0, exception = 1.
  - Next state: RESP.
- MERGE:
  - Same aligned read address.
  - merged = mem_read_data with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0].
  - If mem_read_exception -> RESP with exception = 1, and no write is issued. Otherwise -> WRITE.
- WRITE:
  - mem_write_enable = 1 for exactly this cycle; mem_write_address aligned; mem_write_data = merged.
  - exception = mem_write_exception.
  - Next state: RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_exception stay stable while resp_valid && !resp_ready.
  - On resp_ready -> IDLE. A new request can be accepted on the following cycle; there is no same-cycle turnaround.
- mem_write_enable is 0 in every state except WRITE.
- mem_read_address in IDLE/RESP holds the last latched aligned address.
- Latency from the acceptance edge to resp_valid, with resp_ready held high:
  - misaligned: 1 cycle.
  - load / word store: 2 cycles.
  - byte/half store: 3 cycles.
- Exactly one outstanding request at a time; req_* inputs are ignored outside IDLE.
- Address arithmetic uses only bits [1:0] for lane select. No wrap is possible, since the aligned word never crosses a word boundary.

Test Plan:
- Preload mem[0x100] = 0xAABBCCDD; byte store addr 0x102, wdata 0x11 -> one write strobe to 0x100 with data 0xAA11CCDD; resp_valid 3 cycles after acceptance, exception 0.
- Same preload; signed byte load addr 0x103 -> resp_rdata 0xFFFFFFAA. Unsigned half load addr 0x102 -> 0x0000AABB. Each response arrives 2 cycles after acceptance.
- Word load addr 0x101, CHECK_ALIGN=1 -> resp_exception 1, resp_rdata 0, no memory write, resp_valid 1 cycle after acceptance. Repeat with CHECK_ALIGN=0 -> reads word 0x100, exception 0.
- Half store to 0x104 with mem_read_exception forced 1 during MERGE -> no mem_write_enable pulse, resp_exception 1.
- Word load with resp_ready held low 5 cycles -> resp_valid and resp_rdata remain stable, req_ready stays 0; release resp_ready -> IDLE next cycle, and back-to-back requests are accepted.
- Assert RESET low during WRITE of a byte store -> mem_write_enable drops to 0 asynchronously, memory word unchanged, no response; after release, a word store to 0x108 of 0x12345678 completes normally.
